// File: rtl/fc_pkg.sv
//------------------------------------------------------------------------------
// fc_pkg : shared constants, state type and config check for the FC weight buffer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package fc_pkg;

  localparam int FC_W_LANES       = 120;
  localparam int FC_W_LANE_STRIDE = 128;
  localparam int FC_W_ROWS        = 1024;
  localparam int FC_W_WR_AW       = 17;
  localparam int FC_W_RD_AW       = 10;
  localparam int FC_W_LANE_AW     = $clog2(FC_W_LANE_STRIDE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_READ = 2'd2
  } fc_state_e;

  // Arguments are length-1; bit 10 of in_m1 is set for 0 and for anything above 1024.
  function automatic logic cfg_ok(input logic [10:0] in_m1, input logic [6:0] out_m1);
    return !in_m1[10] && (out_m1 < 7'(FC_W_LANES));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_w_addr_gen.sv
//------------------------------------------------------------------------------
// fc_w_addr_gen : row/lane counter with programmable wrap points and last flag
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fc_w_addr_gen
  import fc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    adv,
  input  logic [FC_W_RD_AW-1:0]   row_last_idx,
  input  logic [FC_W_LANE_AW-1:0] lane_last_idx,
  output logic [FC_W_RD_AW-1:0]   row,
  output logic [FC_W_LANE_AW-1:0] lane,
  output logic                    last
);

  logic [FC_W_RD_AW-1:0]   row_q, row_d;
  logic [FC_W_LANE_AW-1:0] lane_q, lane_d;
  logic                    lane_wrap;
  logic                    row_wrap;

  assign lane_wrap = (lane_q == lane_last_idx);
  assign row_wrap  = (row_q == row_last_idx);

  always_comb begin
    row_d  = row_q;
    lane_d = lane_q;
    if (clr) begin
      row_d  = '0;
      lane_d = '0;
    end else if (adv) begin
      if (lane_wrap) begin
        lane_d = '0;
        row_d  = row_wrap ? '0 : row_q + 1'b1;
      end else begin
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      lane_q <= '0;
    end else begin
      row_q  <= row_d;
      lane_q <= lane_d;
    end
  end

  assign row  = row_q;
  assign lane = lane_q;
  assign last = lane_wrap && row_wrap;

endmodule

`default_nettype wire

// File: rtl/fc_w_buf_ctrl.sv
//------------------------------------------------------------------------------
// fc_w_buf_ctrl : FC weight buffer controller (byte-wise load, row-wise read)
// Optional stall counter output enabled by FC_W_BUF_CTRL_PERF_EN. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fc_w_buf_ctrl
  import fc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           cfg_in_len,
  input  logic [6:0]            cfg_out_len,
  input  logic                  load_start,
  input  logic                  comp_start,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [7:0]            wdata,
  output logic                  wren_o,
  output logic [FC_W_WR_AW-1:0] wrptr_o,
  output logic [7:0]            weight_o,
  output logic                  rden_o,
  output logic [FC_W_RD_AW-1:0] rdptr_o,
  output logic                  row_valid,
  output logic [FC_W_RD_AW-1:0] row_idx,
  output logic                  row_last,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
`ifdef FC_W_BUF_CTRL_PERF_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  fc_state_e               state_q, state_d;
  logic [FC_W_RD_AW-1:0]   in_last_q, in_last_d;
  logic [FC_W_LANE_AW-1:0] out_last_q, out_last_d;
  logic                    remain_q, remain_d;
  logic                    row_valid_q, row_valid_d;
  logic [FC_W_RD_AW-1:0]   row_idx_q, row_idx_d;
  logic                    row_last_q, row_last_d;
  logic                    done_q, done_d;
  logic                    cfg_err_q, cfg_err_d;

  logic [10:0]             in_m1;
  logic [6:0]              out_m1;
  logic                    start_ok;
  logic                    accept;
  logic                    issue;
  logic                    start_read;
  logic                    gen_clr;
  logic                    gen_adv;
  logic [FC_W_RD_AW-1:0]   gen_row;
  logic [FC_W_LANE_AW-1:0] gen_lane;
  logic                    gen_last;
  logic [FC_W_LANE_AW-1:0] lane_last_idx;

  assign in_m1    = cfg_in_len - 11'd1;
  assign out_m1   = cfg_out_len - 7'd1;
  assign start_ok = cfg_ok(in_m1, out_m1);

  assign accept  = (state_q == ST_LOAD) && wdata_valid;
  assign issue   = (state_q == ST_READ) && remain_q && (!row_valid_q || rd_ready);
  assign gen_adv = accept || issue;
  // READ walks rows only, so the lane wrap point collapses to zero there.
  assign lane_last_idx = (state_q == ST_READ) ? '0 : out_last_q;

  fc_w_addr_gen u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (gen_clr),
    .adv          (gen_adv),
    .row_last_idx (in_last_q),
    .lane_last_idx(lane_last_idx),
    .row          (gen_row),
    .lane         (gen_lane),
    .last         (gen_last)
  );

  always_comb begin
    state_d     = state_q;
    in_last_d   = in_last_q;
    out_last_d  = out_last_q;
    remain_d    = remain_q;
    row_valid_d = row_valid_q;
    row_idx_d   = row_idx_q;
    row_last_d  = row_last_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    gen_clr     = 1'b0;
    start_read  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_start || comp_start) begin
          if (start_ok) begin
            state_d    = load_start ? ST_LOAD : ST_READ;
            start_read = !load_start;
            remain_d   = !load_start;
            in_last_d  = in_m1[FC_W_RD_AW-1:0];
            out_last_d = out_m1;
            gen_clr    = 1'b1;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept && gen_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (row_valid_q && rd_ready) begin
          row_valid_d = 1'b0;
          row_last_d  = 1'b0;
          if (row_last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        if (issue) begin
          row_valid_d = 1'b1;
          row_idx_d   = gen_row;
          row_last_d  = gen_last;
          if (gen_last) begin
            remain_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_last_q   <= '0;
      out_last_q  <= '0;
      remain_q    <= 1'b0;
      row_valid_q <= 1'b0;
      row_idx_q   <= '0;
      row_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_last_q   <= in_last_d;
      out_last_q  <= out_last_d;
      remain_q    <= remain_d;
      row_valid_q <= row_valid_d;
      row_idx_q   <= row_idx_d;
      row_last_q  <= row_last_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign wdata_ready = (state_q == ST_LOAD);
  assign wren_o      = accept;
  assign wrptr_o     = accept ? {gen_row, gen_lane} : '0;
  assign weight_o    = accept ? wdata : '0;
  assign rden_o      = issue;
  assign rdptr_o     = issue ? gen_row : '0;
  assign row_valid   = row_valid_q;
  assign row_idx     = row_idx_q;
  assign row_last    = row_last_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

`ifdef FC_W_BUF_CTRL_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_read) begin
      stall_d = '0;
    end else if ((state_q == ST_READ) && row_valid_q && !rd_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fc_w_buf_ctrl.sv
//------------------------------------------------------------------------------
// tb_fc_w_buf_ctrl : vector table, directed corner sequences and random runs
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fc_w_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] cfg_in_len = '0;
  logic [6:0]  cfg_out_len = '0;
  logic        load_start = 1'b0;
  logic        comp_start = 1'b0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [7:0]  wdata = '0;
  logic        wren_o;
  logic [16:0] wrptr_o;
  logic [7:0]  weight_o;
  logic        rden_o;
  logic [9:0]  rdptr_o;
  logic        row_valid;
  logic [9:0]  row_idx;
  logic        row_last;
  logic        rd_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        cfg_err;
`ifdef FC_W_BUF_CTRL_PERF_EN
  logic [15:0] stall_cnt;
`endif

  fc_w_buf_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_in_len (cfg_in_len),
    .cfg_out_len(cfg_out_len),
    .load_start (load_start),
    .comp_start (comp_start),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .wren_o     (wren_o),
    .wrptr_o    (wrptr_o),
    .weight_o   (weight_o),
    .rden_o     (rden_o),
    .rdptr_o    (rdptr_o),
    .row_valid  (row_valid),
    .row_idx    (row_idx),
    .row_last   (row_last),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
`ifdef FC_W_BUF_CTRL_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    load_start  = 1'b0;
    comp_start  = 1'b0;
    wdata_valid = 1'b0;
    rd_ready    = 1'b1;
  endtask

  typedef struct {
    logic        ls, cs, wv;
    logic [10:0] il;
    logic [6:0]  ol;
    logic [7:0]  wd;
    logic        e_busy, e_rdy, e_wren, e_done, e_err;
    logic [16:0] e_ptr;
    logic [7:0]  e_w;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl[NV];

  task automatic build_table();
    int v = 5;
    int k = 0;
    for (int i = 0; i < NV; i++) begin
      tbl[i] = '{ls: 1'b0, cs: 1'b0, wv: 1'b0, il: 11'd3, ol: 7'd4, wd: 8'h00,
                 e_busy: 1'b0, e_rdy: 1'b0, e_wren: 1'b0, e_done: 1'b0, e_err: 1'b0,
                 e_ptr: 17'd0, e_w: 8'h00};
    end
    tbl[0].ls = 1'b1; tbl[0].ol = 7'd121;
    tbl[1].e_err = 1'b1;
    tbl[2].cs = 1'b1; tbl[2].il = 11'd0;
    tbl[3].e_err = 1'b1;
    tbl[4].ls = 1'b1; tbl[4].cs = 1'b1;
    // 12 bytes for a 3x4 load with one idle gap; cfg inputs wiggle and must be ignored
    for (int j = 0; j < 13; j++) begin
      tbl[v].il = 11'd7; tbl[v].ol = 7'd9;
      tbl[v].e_busy = 1'b1; tbl[v].e_rdy = 1'b1;
      if (j != 6) begin
        tbl[v].wv     = 1'b1;
        tbl[v].wd     = 8'(k * 17 + 3);
        tbl[v].e_wren = 1'b1;
        tbl[v].e_ptr  = 17'((k / 4) * 128 + (k % 4));
        tbl[v].e_w    = 8'(k * 17 + 3);
        k++;
      end
      v++;
    end
    tbl[18].e_done = 1'b1;
  endtask

  task automatic run_load(input int il, input int ol);
    int total = il * ol;
    int cnt = 0;
    int cyc = 0;
    bit fin = 0;
    logic [16:0] exp_ptr;
    @(negedge clk);
    load_start = 1'b1; cfg_in_len = 11'(il); cfg_out_len = 7'(ol);
    #1;
    chk("ld_start_busy", busy, 1'b0);
    while (!fin && cyc < total * 3 + 100) begin
      @(negedge clk);
      cyc++;
      load_start  = ($urandom % 16) == 0;
      comp_start  = ($urandom % 16) == 0;
      cfg_in_len  = 11'($urandom);
      cfg_out_len = 7'($urandom);
      wdata_valid = ($urandom % 4) != 0;
      wdata       = 8'($urandom);
      #1;
      chk("ld_ready", wdata_ready, 1'b1);
      if (wdata_valid) begin
        exp_ptr = 17'((cnt / ol) * 128 + (cnt % ol));
        chk("ld_wren", wren_o, 1'b1);
        chk("ld_wrptr", wrptr_o, exp_ptr);
        chk("ld_weight", weight_o, wdata);
        cnt++;
        if (cnt == total) fin = 1;
      end else begin
        chk("ld_no_wren", wren_o, 1'b0);
      end
    end
    if (!fin) chk("ld_timeout", 32'd0, 32'd1);
    @(negedge clk);
    drive_idle();
    #1;
    chk("ld_done", done, 1'b1);
    chk("ld_idle", busy, 1'b0);
    chk("ld_ready_off", wdata_ready, 1'b0);
    chk("ld_write_count", 32'(cnt), 32'(total));
  endtask

  task automatic run_read(input int n);
    int next_row = 0;
    bit exp_v = 0;
    int exp_idx = 0;
    bit fin = 0;
    int stalls = 0;
    int cyc = 0;
    bit iss;
    bit acc;
    @(negedge clk);
    comp_start = 1'b1; cfg_in_len = 11'(n); cfg_out_len = 7'd120; rd_ready = 1'b1;
    #1;
    chk("rr_start_busy", busy, 1'b0);
    while (!fin && cyc < 20 * n + 50) begin
      @(negedge clk);
      cyc++;
      comp_start = ($urandom % 8) == 0;
      load_start = ($urandom % 8) == 0;
      cfg_in_len = 11'($urandom_range(1, 1024));
      rd_ready   = ($urandom % 10) < 7;
      #1;
      iss = (next_row < n) && (!exp_v || rd_ready);
      chk("rr_busy", busy, 1'b1);
      chk("rr_valid", row_valid, exp_v);
      chk("rr_rden", rden_o, iss);
      if (iss) chk("rr_rdptr", rdptr_o, 32'(next_row));
      if (exp_v) begin
        chk("rr_idx", row_idx, 32'(exp_idx));
        chk("rr_last", row_last, exp_idx == n - 1);
      end
      acc = exp_v && rd_ready;
      if (exp_v && !rd_ready) stalls++;
      if (acc && exp_idx == n - 1) fin = 1;
      if (iss) begin
        exp_v = 1; exp_idx = next_row; next_row++;
      end else if (acc) begin
        exp_v = 0;
      end
    end
    if (!fin) chk("rr_timeout", 32'd0, 32'd1);
    @(negedge clk);
    drive_idle();
    #1;
    chk("rr_done", done, 1'b1);
    chk("rr_idle", busy, 1'b0);
    chk("rr_valid_off", row_valid, 1'b0);
`ifdef FC_W_BUF_CTRL_PERF_EN
    chk("rr_stall_cnt", stall_cnt, 32'(stalls));
`endif
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_table();

    // Reset values
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", wdata_ready, 1'b0);
    chk("rst_wren", wren_o, 1'b0);
    chk("rst_wrptr", wrptr_o, 17'd0);
    chk("rst_rden", rden_o, 1'b0);
    chk("rst_rdptr", rdptr_o, 10'd0);
    chk("rst_valid", row_valid, 1'b0);
    chk("rst_idx", row_idx, 10'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: illegal configs, simultaneous starts, 3x4 load
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      load_start = tbl[i].ls; comp_start = tbl[i].cs;
      cfg_in_len = tbl[i].il; cfg_out_len = tbl[i].ol;
      wdata_valid = tbl[i].wv; wdata = tbl[i].wd;
      #1;
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_ready", i), wdata_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_wren", i), wren_o, tbl[i].e_wren);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].e_err);
      if (tbl[i].e_wren) begin
        chk($sformatf("tbl%0d_wrptr", i), wrptr_o, tbl[i].e_ptr);
        chk($sformatf("tbl%0d_weight", i), weight_o, tbl[i].e_w);
      end
    end

    // READ of 5 rows with rd_ready held high
    @(negedge clk);
    comp_start = 1'b1; cfg_in_len = 11'd5; cfg_out_len = 7'd1; rd_ready = 1'b1;
    #1;
    chk("rd5_start_busy", busy, 1'b0);
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      comp_start = 1'b0;
      #1;
      chk($sformatf("rd5_t%0d_rden", t), rden_o, t <= 5);
      if (t <= 5) chk($sformatf("rd5_t%0d_rdptr", t), rdptr_o, 32'(t - 1));
      chk($sformatf("rd5_t%0d_valid", t), row_valid, (t >= 2) && (t <= 6));
      if (t >= 2 && t <= 6) begin
        chk($sformatf("rd5_t%0d_idx", t), row_idx, 32'(t - 2));
        chk($sformatf("rd5_t%0d_last", t), row_last, t == 6);
      end
      chk($sformatf("rd5_t%0d_done", t), done, t == 7);
      chk($sformatf("rd5_t%0d_busy", t), busy, t != 7);
    end

    // READ with consumer stalled for 3 cycles on row 2
    @(negedge clk);
    comp_start = 1'b1; cfg_in_len = 11'd5; cfg_out_len = 7'd8; rd_ready = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      comp_start = 1'b0;
    end
    for (int t = 4; t <= 6; t++) begin
      @(negedge clk);
      rd_ready = 1'b0;
      #1;
      chk("stall_valid", row_valid, 1'b1);
      chk("stall_idx", row_idx, 10'd2);
      chk("stall_rden", rden_o, 1'b0);
    end
    @(negedge clk);
    rd_ready = 1'b1;
    #1;
    chk("stall_rel_rden", rden_o, 1'b1);
    chk("stall_rel_rdptr", rdptr_o, 10'd3);
    chk("stall_rel_idx", row_idx, 10'd2);
`ifdef FC_W_BUF_CTRL_PERF_EN
    chk("stall_cnt3", stall_cnt, 16'd3);
`endif
    begin : wait_done
      bit seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        #1;
        if (done) seen = 1;
      end
      chk("stall_done_seen", seen, 1'b1);
    end

    // Asynchronous reset in the middle of row 2 of a load
    @(negedge clk);
    load_start = 1'b1; cfg_in_len = 11'd5; cfg_out_len = 7'd4;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      wdata_valid = 1'b1; wdata = 8'(k + 1);
      if (k < 8) @(negedge clk);
    end
    #1;
    chk("arst_pre_wrptr", wrptr_o, 17'd256);
    chk("arst_pre_wren", wren_o, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wren", wren_o, 1'b0);
    chk("arst_wrptr", wrptr_o, 17'd0);
    chk("arst_weight", weight_o, 8'd0);
    chk("arst_ready", wdata_ready, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    #1;
    chk("arst_post_busy", busy, 1'b0);
    @(negedge clk);
    comp_start = 1'b1; cfg_in_len = 11'd3; cfg_out_len = 7'd4;
    @(negedge clk);
    comp_start = 1'b0;
    #1;
    chk("arst_read_rden", rden_o, 1'b1);
    chk("arst_read_rdptr", rdptr_o, 10'd0);
    begin : wait_done2
      bit seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        #1;
        if (done) seen = 1;
      end
      chk("arst_read_done_seen", seen, 1'b1);
    end

    // Randomized loads and reads against the reference model
    run_load(1024, 1);
    run_load(64, 120);
    for (int r = 0; r < 3; r++) begin
      run_load($urandom_range(1, 30), $urandom_range(1, 120));
    end
    for (int r = 0; r < 4; r++) begin
      run_read($urandom_range(1, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fc_w_buf_ctrl.md
FC_W_BUF_CTRL -- requirements
Module: fc_w_buf_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: cfg_in_len  input  11  rows (FC input length), legal 1..1024.
REQ-004 SHALL have ports: cfg_out_len  input  7  lanes used per row (FC output length), legal 1..120.
REQ-005 SHALL have ports: load_start  input  1  pulse, begin weight load.
REQ-006 SHALL have ports: comp_start  input  1  pulse, begin row read pass.
REQ-007 SHALL have ports: wdata_valid / wdata_ready  input / output  1 / 1  weight stream handshake; wdata  input  8  signed weight byte.
REQ-008 SHALL have ports: wren_o  output  1, wrptr_o  output  17, weight_o  output  8  buffer write port.
REQ-009 SHALL have ports: rden_o  output  1, rdptr_o  output  10  buffer row read port.
REQ-010 SHALL have ports: row_valid  output  1, row_idx  output  10, row_last  output  1  buffer 120-byte row output qualifiers; rd_ready  input  1  consumer accepts row.
REQ-011 SHALL have ports: busy  output  1, done  output  1  (one-cycle pulse), cfg_err  output  1  (one-cycle pulse).

Function
REQ-012 SHALL implement states IDLE, LOAD, READ; busy=1 outside IDLE.
REQ-013 IDLE: load_start with legal config -> LOAD; else comp_start with legal config -> READ; both same cycle -> LOAD wins, comp_start dropped.
REQ-014 Start with cfg_in_len outside 1..1024 or cfg_out_len outside 1..120 SHALL stay IDLE and pulse cfg_err next cycle.
REQ-015 cfg_in_len/cfg_out_len SHALL be latched at start; changes mid-operation ignored; starts while busy ignored.
REQ-016 LOAD: wdata_ready=1; each wdata_valid&&wdata_ready cycle drives wren_o=1, wrptr_o={row[9:0],lane[6:0]}, weight_o=wdata combinationally same cycle.
REQ-017 Lane increments 0..cfg_out_len-1 then wraps to 0 with row+1; lanes cfg_out_len..127 never written.
REQ-018 Last byte (row=in_len-1, lane=out_len-1) accepted -> IDLE next cycle, done pulse that cycle, wdata_ready=0.
REQ-019 READ: rden_o=1 with rdptr_o=next row when rows remain and (!row_valid || rd_ready); buffer latency 1 cycle, so row_valid=1 the cycle after rden_o with row_idx=that row.
REQ-020 row_valid SHALL hold with stable row_idx while !rd_ready; no rden_o issued during hold; full throughput of one row/cycle when rd_ready=1.
REQ-021 row_last=1 with row_valid for row in_len-1; its acceptance -> IDLE next cycle, done pulse.
REQ-022 Reset values: all outputs 0 (wrptr_o, rdptr_o, row_idx 0; wdata_ready, wren_o, rden_o, row_valid, busy, done, cfg_err 0).

Reset
REQ-023 rst_n low SHALL force IDLE and reset values immediately, independent of clk, including mid-LOAD or mid-READ; no write or read issued until a new start after release.
REQ-024 Partially loaded contents after reset SHALL be undefined; controller keeps no memory of them.

Configuration
REQ-025 Macro FC_W_BUF_CTRL_PERF_EN defined: output stall_cnt 16 bits counts READ cycles with row_valid && !rd_ready, saturates at 65535, cleared at accepted comp_start, holds value in IDLE.
REQ-026 Macro undefined: stall_cnt port and logic absent; all other behaviour identical.

Structure
REQ-027 Shared package fc_pkg SHALL hold FC_W_LANES=120, FC_W_LANE_STRIDE=128, FC_W_ROWS=1024, address widths 17/10, and the state enum.
REQ-028 Row/lane counter with wrap and last detection SHALL be sub-module fc_w_addr_gen, instanced for LOAD and reused for READ row count.

Verification
REQ-029 in_len=3, out_len=4, 12 valid bytes back-to-back -> wrptr_o 0,1,2,3,128..131,256..259, done on 12th accept.
REQ-030 out_len=120, in_len=1024, random wdata_valid gaps -> final wrptr_o 0x1FFF7, exactly 122880 writes, no write when wdata_valid=0.
REQ-031 READ in_len=5, rd_ready held 1 -> rden_o rows 0..4 on consecutive cycles, row_valid one cycle later, row_last on row 4, done after it.
REQ-032 READ with rd_ready low 3 cycles at row 2 -> row_idx stays 2, no rden_o, stall_cnt=3 (PERF_EN).
REQ-033 load_start and comp_start same cycle -> LOAD; cfg_out_len=121 -> cfg_err pulse, busy stays 0.
REQ-034 rst_n low at row 2 of LOAD -> all outputs 0 asynchronously; subsequent comp_start reads from row 0.
